// File: rtl/imem_fetch_ctrl.sv
// Instruction memory port arbiter and boot sequencer:
// host program load over valid/ready, then PC-driven fetch until halt.
module imem_fetch_ctrl #(
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  input  logic              run,
  input  logic              stop,
  input  logic [31:0]       next_pc,
  output logic [31:0]       pc,
  output logic              cpu_en,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              fault,
  output logic              loaded,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_HALT
  } state_t;

  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t state, state_d;

  logic in_run;
  logic parked;
  logic xfer;
  logic pc_bad;
  logic hit_halt;
  logic halting;
  logic set_fault;
  logic start;

  assign in_run   = (state == S_RUN);
  assign parked   = (state == S_IDLE) || (state == S_HALT);
  assign xfer     = load_valid & load_ready;
  assign pc_bad   = (|next_pc[1:0]) | (|next_pc[31:ADDR_W+2]);
  assign hit_halt = (mem_rdata == HALT_WORD);
  assign halting  = in_run & (stop | hit_halt | pc_bad);
  // fault only when the bad PC is the reason for stopping
  assign set_fault = in_run & ~stop & ~hit_halt & pc_bad;
  assign start    = parked & ~xfer & run & loaded;

  always_comb begin
    state_d     = state;
    load_ready  = 1'b1;
    cpu_en      = 1'b0;
    instruction = 32'h0000_0000;
    mem_addr    = load_addr;
    mem_we      = xfer;
    mem_wdata   = load_data;
    busy        = 1'b0;
    unique case (state)
      S_IDLE, S_HALT: begin
        if (xfer)
          state_d = load_last ? S_IDLE : S_LOAD;
        else if (start)
          state_d = S_RUN;
      end
      S_LOAD: begin
        busy = 1'b1;
        if (xfer && load_last)
          state_d = S_IDLE;
      end
      S_RUN: begin
        busy        = 1'b1;
        load_ready  = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = pc[ADDR_W+1:2];
        instruction = mem_rdata;
        cpu_en      = ~halting;
        if (halting)
          state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      fault      <= 1'b0;
      loaded     <= 1'b0;
      word_count <= '0;
    end else begin
      state <= state_d;
      if (xfer) begin
        loaded <= load_last;
        if (parked) begin
          word_count <= {{ADDR_W{1'b0}}, 1'b1};
          fault      <= 1'b0;
        end else if (word_count != CNT_MAX) begin
          word_count <= word_count + 1'b1;
        end
      end
      if (start)
        pc <= RESET_PC;
      else if (in_run && !halting)
        pc <= next_pc;
      if (set_fault)
        fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural 64-word memory.
module tb_imem_fetch_ctrl;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              load_last;
  logic              run;
  logic              stop;
  logic [31:0]       next_pc;
  logic [31:0]       pc;
  logic              cpu_en;
  logic [31:0]       instruction;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              busy;
  logic              fault;
  logic              loaded;
  logic [ADDR_W:0]   word_count;

  logic        npc_ovr;
  logic [31:0] npc_val;
  logic [31:0] mem [64];
  logic [31:0] prog [16];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0000_0000),
    .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_last  (load_last),
    .run        (run),
    .stop       (stop),
    .next_pc    (next_pc),
    .pc         (pc),
    .cpu_en     (cpu_en),
    .instruction(instruction),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .fault      (fault),
    .loaded     (loaded),
    .word_count (word_count)
  );

  always_ff @(posedge clk)
    if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];
  assign next_pc   = npc_ovr ? npc_val : pc + 32'd4;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_prog(input bit halt4);
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b1;
      load_addr  = ADDR_W'(i);
      load_data  = (halt4 && i == 4) ? 32'hFFFF_FFFF : prog[i];
      load_last  = (i == 15);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    prog = '{32'h20020005, 32'h2003000c, 32'h2067fff7, 32'h00e22025,
             32'h00642824, 32'h00a42820, 32'h10a7000a, 32'h0064202a,
             32'h10800001, 32'h20050000, 32'h00e2202a, 32'h00853820,
             32'h00e23822, 32'hac670044, 32'h8c020050, 32'hac470047};
    reset = 1'b1; load_valid = 1'b0; load_addr = '0; load_data = '0;
    load_last = 1'b0; run = 1'b0; stop = 1'b0;
    npc_ovr = 1'b0; npc_val = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_cpu_en", 32'(cpu_en), 32'h0);
    check("rst_ready", 32'(load_ready), 32'h1);
    check("rst_we", 32'(mem_we), 32'h0);
    check("rst_instr", instruction, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_loaded", 32'(loaded), 32'h0);
    check("rst_wcount", 32'(word_count), 32'h0);

    // run with nothing loaded is ignored
    run = 1'b1; tick(); run = 1'b0;
    check("run_unloaded_busy", 32'(busy), 32'h0);
    check("run_unloaded_en", 32'(cpu_en), 32'h0);

    // program load
    load_prog(1'b0);
    check("load_loaded", 32'(loaded), 32'h1);
    check("load_wcount", 32'(word_count), 32'd16);
    check("load_busy", 32'(busy), 32'h0);

    // run and fetch sequence
    run = 1'b1; tick(); run = 1'b0;
    check("run_pc0", pc, 32'h0);
    check("run_instr0", instruction, 32'h20020005);
    check("run_cpu_en", 32'(cpu_en), 32'h1);
    check("run_busy", 32'(busy), 32'h1);
    for (int k = 1; k < 16; k++) begin
      tick();
      check($sformatf("fetch%0d", k), instruction, prog[k]);
    end
    check("run_pc3c", pc, 32'h3C);

    // host offer during RUN is refused; stop halts in same cycle
    load_valid = 1'b1; load_addr = 6'd5; load_data = 32'hDEADBEEF;
    stop = 1'b1;
    #1;
    check("run_ready", 32'(load_ready), 32'h0);
    check("run_no_we", 32'(mem_we), 32'h0);
    check("stop_en", 32'(cpu_en), 32'h0);
    tick();
    load_valid = 1'b0; stop = 1'b0;
    #1;
    check("stop_pc", pc, 32'h3C);
    check("stop_busy", 32'(busy), 32'h0);
    check("stop_nowrite", mem[5], prog[5]);

    // halt word at address 4
    load_prog(1'b1);
    run = 1'b1; tick(); run = 1'b0;
    tick(); tick(); tick(); tick();
    check("halt_instr", instruction, 32'hFFFF_FFFF);
    check("halt_en", 32'(cpu_en), 32'h0);
    check("halt_pc_k", pc, 32'h10);
    tick();
    check("halt_pc", pc, 32'h10);
    check("halt_busy", 32'(busy), 32'h0);
    check("halt_fault", 32'(fault), 32'h0);
    check("halt_en2", 32'(cpu_en), 32'h0);

    // misaligned next_pc
    load_prog(1'b0);
    npc_ovr = 1'b1; npc_val = 32'h0000_0102;
    run = 1'b1; tick(); run = 1'b0;
    check("mis_en", 32'(cpu_en), 32'h0);
    tick();
    check("mis_fault", 32'(fault), 32'h1);
    check("mis_pc", pc, 32'h0);
    check("mis_busy", 32'(busy), 32'h0);

    // new load clears fault
    load_valid = 1'b1; load_addr = '0; load_data = prog[0];
    tick();
    load_valid = 1'b0;
    check("reload_fault", 32'(fault), 32'h0);
    check("reload_busy", 32'(busy), 32'h1);
    check("reload_wcount", 32'(word_count), 32'h1);
    check("reload_loaded", 32'(loaded), 32'h0);
    load_prog(1'b0);

    // out-of-range next_pc
    npc_val = 32'h0000_0100;
    run = 1'b1; tick(); run = 1'b0;
    check("oor_en", 32'(cpu_en), 32'h0);
    tick();
    check("oor_fault", 32'(fault), 32'h1);
    check("oor_busy", 32'(busy), 32'h0);
    npc_ovr = 1'b0;

    // transfer beats run in IDLE
    load_prog(1'b0);
    run = 1'b1; load_valid = 1'b1; load_addr = 6'd20;
    load_data = 32'h1234_5678;
    #1;
    check("race_we", 32'(mem_we), 32'h1);
    tick();
    load_valid = 1'b0;
    check("race_busy", 32'(busy), 32'h1);
    check("race_en", 32'(cpu_en), 32'h0);
    check("race_mem", mem[20], 32'h1234_5678);
    check("race_loaded", 32'(loaded), 32'h0);
    tick();
    run = 1'b0;
    check("load_run_ign", 32'(cpu_en), 32'h0);
    reset = 1'b1; tick(); reset = 1'b0;

    // reset in RUN at pc 0x20
    load_prog(1'b0);
    run = 1'b1; tick(); run = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check("rrun_pc20", pc, 32'h20);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rrun_pc", pc, 32'h0);
    check("rrun_loaded", 32'(loaded), 32'h0);
    check("rrun_en", 32'(cpu_en), 32'h0);
    check("rrun_busy", 32'(busy), 32'h0);
    check("rrun_mem", mem[3], prog[3]);

    // word_count saturation
    for (int i = 0; i < 66; i++) begin
      load_valid = 1'b1;
      load_addr  = ADDR_W'(i);
      load_data  = 32'hA000_0000 + 32'(i);
      load_last  = (i == 65);
      tick();
      if (i == 63) check("sat_64", 32'(word_count), 32'd64);
    end
    load_valid = 1'b0; load_last = 1'b0;
    check("sat_hold", 32'(word_count), 32'd64);
    check("sat_write", mem[1], 32'hA000_0041);
    check("sat_loaded", 32'(loaded), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
